// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI transaction sequencer.
// Contents: controller state encoding, default timing parameters and the
// width of the internal timers/byte counter.
package spi_ctrl_pkg;

  localparam int CNT_W        = 4;
  localparam int CS_SETUP_DEF = 4;
  localparam int CS_HOLD_DEF  = 4;
  localparam int BYTE_GAP_DEF = 0;
  localparam int CS_IDLE_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEND,
    ST_WAIT,
    ST_GAP,
    ST_HOLD,
    ST_RELEASE
  } txn_state_t;

endpackage

// File: rtl/spi_rr_arb.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   req[1:0]    - requests
//   update      - pulse: the current winner is being served, rotate priority
//   win[1:0]    - one-hot winner (combinational), 2'b00 when no request
// After reset requester 0 has priority; the last-served requester drops
// to lower priority. A lone requester always wins.
module spi_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] win
);

  // 1: requester 1 currently has priority
  logic prio_q, prio_d;

  always_comb begin
    win = req;
    if (req == 2'b11) win = prio_q ? 2'b10 : 2'b01;
  end

  always_comb begin
    prio_d = prio_q;
    if (update && (win != 2'b00)) prio_d = win[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

endmodule

// File: rtl/spi_txn_ctrl.sv
// Transaction sequencer and two-way arbiter in front of the SPI byte engine.
// Grants one requester at a time, drives its chip select with setup/hold
// spacing, and issues len+1 byte transfers to the engine, returning each
// received byte. The engine itself (with rst = ~rst_n) lives one level up.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   req[1:0]            - level requests, held until done
//   len0/len1           - byte count minus one, sampled at grant
//   wdata0/wdata1       - next TX byte of each requester
//   gnt[1:0]            - one-hot grant
//   wdata_rd            - pulse: granted wdata consumed
//   rdata, rdata_vld    - received byte and its valid pulse
//   done                - pulse: transaction finished
//   cs_n[1:0]           - chip selects, active low
//   eng_begin, eng_data - engine tx_begin / tx_data
//   eng_end, eng_rx     - engine tx_end / rx_data
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | waiting for a request; arbitration happens here
// ST_SETUP   | cs_n low, counting CS_SETUP before first byte
// ST_SEND    | one-cycle eng_begin for the current byte
// ST_WAIT    | waiting for eng_end of the current byte
// ST_GAP     | BYTE_GAP idle cycles between bytes
// ST_HOLD    | counting CS_HOLD after the last byte
// ST_RELEASE | cs_n high, counting CS_IDLE; requests ignored
module spi_txn_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF,
  parameter int BYTE_GAP = BYTE_GAP_DEF,
  parameter int CS_IDLE  = CS_IDLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [3:0] len0,
  input  logic [3:0] len1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic       wdata_rd,
  output logic [7:0] rdata,
  output logic       rdata_vld,
  output logic       done,
  output logic [1:0] cs_n,
  output logic       eng_begin,
  output logic [7:0] eng_data,
  input  logic       eng_end,
  input  logic [7:0] eng_rx
);

  // Timers are down-counters loaded with N-1 so each wait lasts N cycles.
  // GAP_LD is unused when BYTE_GAP is 0.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(BYTE_GAP - 1);
  localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(CS_IDLE - 1);

  txn_state_t       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       cs_n_q, cs_n_d;
  logic             eng_begin_q, eng_begin_d;
  logic [7:0]       eng_data_q, eng_data_d;
  logic             wdata_rd_q, wdata_rd_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rdata_vld_q, rdata_vld_d;
  logic             done_q, done_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;

  logic [1:0] arb_win;
  logic       arb_update;
  logic       enter_send;

  spi_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (arb_update),
    .win    (arb_win)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cs_n_d      = cs_n_q;
    eng_begin_d = 1'b0;
    eng_data_d  = eng_data_q;
    wdata_rd_d  = 1'b0;
    rdata_d     = rdata_q;
    rdata_vld_d = 1'b0;
    done_d      = 1'b0;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    tmr_d       = tmr_q;
    arb_update  = 1'b0;
    enter_send  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          arb_update = 1'b1;
          gnt_d      = arb_win;
          cs_n_d     = ~arb_win;
          len_d      = arb_win[1] ? len1 : len0;
          byte_cnt_d = '0;
          tmr_d      = SETUP_LD;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_q == '0) enter_send = 1'b1;
        else             tmr_d = tmr_q - 1'b1;
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_end) begin
          rdata_d     = eng_rx;
          rdata_vld_d = 1'b1;
          if (byte_cnt_q == len_q) begin
            tmr_d   = HOLD_LD;
            state_d = ST_HOLD;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            if (BYTE_GAP == 0) begin
              enter_send = 1'b1;
            end else begin
              tmr_d   = GAP_LD;
              state_d = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (tmr_q == '0) enter_send = 1'b1;
        else             tmr_d = tmr_q - 1'b1;
      end
      ST_HOLD: begin
        if (tmr_q == '0) begin
          cs_n_d  = 2'b11;
          gnt_d   = 2'b00;
          done_d  = 1'b1;
          tmr_d   = IDLE_LD;
          state_d = ST_RELEASE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RELEASE: begin
        if (tmr_q == '0) state_d = ST_IDLE;
        else             tmr_d = tmr_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte launch is registered so eng_begin, eng_data and wdata_rd all
    // appear together in the SEND cycle.
    if (enter_send) begin
      state_d     = ST_SEND;
      eng_begin_d = 1'b1;
      wdata_rd_d  = 1'b1;
      eng_data_d  = gnt_q[1] ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      cs_n_q      <= 2'b11;
      eng_begin_q <= 1'b0;
      eng_data_q  <= 8'h00;
      wdata_rd_q  <= 1'b0;
      rdata_q     <= 8'h00;
      rdata_vld_q <= 1'b0;
      done_q      <= 1'b0;
      len_q       <= 4'h0;
      byte_cnt_q  <= 4'h0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cs_n_q      <= cs_n_d;
      eng_begin_q <= eng_begin_d;
      eng_data_q  <= eng_data_d;
      wdata_rd_q  <= wdata_rd_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      done_q      <= done_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      tmr_q       <= tmr_d;
    end
  end

  assign gnt       = gnt_q;
  assign cs_n      = cs_n_q;
  assign eng_begin = eng_begin_q;
  assign eng_data  = eng_data_q;
  assign wdata_rd  = wdata_rd_q;
  assign rdata     = rdata_q;
  assign rdata_vld = rdata_vld_q;
  assign done      = done_q;

endmodule

// File: doc/spi_txn_ctrl.md
# spi_txn_ctrl

Transaction sequencer and two-way arbiter placed in front of the `SPI` byte engine. It shares the engine between two requesters, each owning one SPI device with its own chip select. For the granted requester it asserts chip select, enforces setup and hold times, and issues 1–16 byte transfers back to back. Each transmitted byte is fetched from the requester, and each received byte is returned to it.

## Interface
- `CS_SETUP`, default 4: cycles with `cs_n` low before the first `eng_begin` (1..15).
- `CS_HOLD`, default 4: cycles after the last `eng_end` before `cs_n` rises (1..15).
- `BYTE_GAP`, default 0: idle cycles between a byte's `eng_end` and the next `eng_begin` (0..15).
- `CS_IDLE`, default 2: minimum cycles `cs_n` stays high between transactions (1..15).

Clock is `clk`, the single clock. `rst_n` is a synchronous, active-low reset.

- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `req`  in  2  per-requester transaction request; level, held until `done`
- `len0`, `len1`  in  4 each  byte count minus one; sampled at grant
- `wdata0`, `wdata1`  in  8 each  next TX byte from each requester
- `gnt`  out  2  one-hot grant; 2'b00 when idle
- `wdata_rd`  out  1  pulse: granted requester's wdata consumed, present next byte
- `rdata`  out  8  last received byte
- `rdata_vld`  out  1  pulse: `rdata` updated
- `done`  out  1  pulse: granted transaction finished
- `cs_n`  out  2  per-device chip select, active low
- `eng_begin`  out  1  to engine `tx_begin`
- `eng_data`  out  8  to engine `tx_data`
- `eng_end`  in  1  from engine `tx_end` (1-cycle pulse)
- `eng_rx`  in  8  from engine `rx_data`

## Operation
- States: IDLE → SETUP → SEND → WAIT → (GAP → SEND | HOLD) → RELEASE → IDLE.
- IDLE:
  - If `req` != 0, choose the winner by round-robin.
  - Latch the winner's `len` into `len_q`, set `gnt`, clear `byte_cnt`, drive that `cs_n` bit low, and go to SETUP.
- Round-robin priority:
  - The last-served requester has lower priority.
  - After reset, requester 0 has priority.
  - When only one requester is active, it wins every time.
- SETUP: count `CS_SETUP` cycles, then go to SEND.
- SEND (exactly one cycle):
  - Assert `eng_begin` = 1, drive `eng_data` with the granted `wdata`, and pulse `wdata_rd`.
  - Then go to WAIT.
- WAIT: on `eng_end`:
  - Register `rdata` <= `eng_rx` and pulse `rdata_vld` on the next cycle.
  - If `byte_cnt` == `len_q`, go to HOLD.
  - Otherwise increment `byte_cnt` (4-bit, never wraps) and go to GAP, or directly to SEND when `BYTE_GAP` = 0.
- GAP: count `BYTE_GAP` cycles, then go to SEND.
- HOLD: count `CS_HOLD` cycles, then drive `cs_n` to 2'b11, clear `gnt`, pulse `done`, and go to RELEASE.
- RELEASE: count `CS_IDLE` cycles, then go to IDLE. Requests are not sampled during RELEASE.
- `eng_end` outside WAIT is ignored.
- `req` deasserting mid-transaction does not abort; the transaction completes. `len` and the non-granted requester's ports are ignored while granted.
- Reset values: `gnt` = 0, `cs_n` = 2'b11, `eng_begin` = 0, `eng_data` = 0, `wdata_rd` = 0, `rdata` = 0, `rdata_vld` = 0, `done` = 0, state IDLE, RR priority to requester 0.
- Reset mid-transaction forces all of the above on the reset edge. The top level drives the engine's `rst` = ~`rst_n`, so the engine aborts in the same cycle.

## Timing
- All outputs are registered.
- Grant latency: IDLE decision cycle, then `gnt` and `cs_n` change on the next edge.
- From `cs_n` falling to the `eng_begin` pulse: `CS_SETUP` cycles.
- `eng_begin` is high for exactly 1 cycle per byte; the engine is guaranteed idle at that point.
- `eng_end` at cycle t gives `rdata_vld` at t+1.
  - With `BYTE_GAP` = 0, the next `eng_begin` is at t+1.
  - Otherwise it is at t+1+`BYTE_GAP`.
- After the final `eng_end` at t: `cs_n` rises, `gnt` clears and `done` pulses together at t+1+`CS_HOLD`.
- `wdata_rd` and `eng_begin` are coincident. The requester must present its next byte within `BYTE_GAP`+1 cycles (by the next SEND). The first byte must be valid when `req` rises.

## Structure
- Package `spi_ctrl_pkg`:
  - state enum `txn_state_t`
  - parameter defaults and counter width `CNT_W` = 4
- Sub-module `spi_rr_arb`: 2-way round-robin arbiter.
  - Inputs: `req`[1:0], `update` pulse.
  - Outputs: one-hot `win`; holds the priority pointer.
- The controller instantiates one `spi_rr_arb`. The engine is instantiated at the top level, not inside this block.

## Test plan
- Reset → `cs_n` = 2'b11, `gnt` = 0, and all pulses 0 for 3 cycles after `rst_n` rises with `req` = 0.
- `req` = 2'b01, `len0` = 2, `wdata0` = 8'hA5, 8'h3C, 8'hFF; engine model echoes complemented bytes:
  - exactly 3 `eng_begin` pulses with the wdata values in order
  - `rdata_vld` values 8'h5A, 8'hC3, 8'h00
  - one `done`; `cs_n`[0] low for `CS_SETUP` + 3 bytes + `CS_HOLD`
- `req` = 2'b11 held, both with `len` = 0 → grants alternate 01, 10, 01; `cs_n` high for at least `CS_IDLE` between transactions.
- `BYTE_GAP` = 3, `len1` = 1 → the second `eng_begin` occurs exactly 4 cycles after the first `eng_end`.
- Spurious `eng_end` in SETUP, and `req` dropped mid-transaction → neither changes the byte count; the transaction completes with `done`.
- `rst_n` low during WAIT of byte 2 → next cycle `cs_n` = 2'b11, `gnt` = 0; after release the first grant goes to requester 0.
